// File: rtl/code_mem_loader.sv
// Byte-stream program loader: frames length + LE payload + XOR check byte into sequential
// 32-bit code memory writes, holding the CPU in reset until a good image has landed.
module code_mem_loader #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned MAX_WORDS  = 512
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [7:0]            in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic                  cpu_resetn_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [ADDR_WIDTH:0]   words_loaded_o
);

   typedef enum logic [2:0] {
      StLenLo,
      StLenHi,
      StData,
      StCheck,
      StDone,
      StError
   } state_e;

   localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

   state_e                state_q;
   logic [15:0]           len_q;
   logic [7:0]            acc_q;
   logic [1:0]            idx_q;
   logic [23:0]           word_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [31:0]           mem_wdata_q;
   logic                  cpu_resetn_q;
   logic                  done_q;
   logic                  error_q;
   logic [ADDR_WIDTH:0]   words_loaded_q;

   logic                  accept;
   logic [15:0]           len_d;
   logic [ADDR_WIDTH:0]   words_loaded_d;
   logic                  last_word;

   always_comb begin
      in_ready_o = 1'b0;
      if (!start_i) begin
         in_ready_o = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StCheck);
      end
   end

   assign accept         = in_valid_i && in_ready_o;
   assign len_d          = {in_data_i, len_q[7:0]};
   assign words_loaded_d = words_loaded_q + 1'b1;
   assign last_word      = (16'(words_loaded_d) == len_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StLenLo;
         len_q          <= '0;
         acc_q          <= '0;
         idx_q          <= '0;
         word_q         <= '0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         cpu_resetn_q   <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         words_loaded_q <= '0;
      end else begin
         mem_we_q <= 1'b0;
         if (start_i) begin
            // Abort: memory contents stay, only the framing state is re-armed.
            state_q        <= StLenLo;
            len_q          <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            word_q         <= '0;
            cpu_resetn_q   <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
         end else if (accept) begin
            if (state_q != StCheck) begin
               acc_q <= acc_q ^ in_data_i;
            end
            case (state_q)
               StLenLo: begin
                  len_q[7:0] <= in_data_i;
                  state_q    <= StLenHi;
               end
               StLenHi: begin
                  len_q <= len_d;
                  if (len_d == 16'd0) begin
                     state_q <= StCheck;
                  end else if (len_d > MaxLen) begin
                     state_q <= StError;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= StData;
                  end
               end
               StData: begin
                  // Bytes arrive LSB first, so shift in from the top.
                  word_q <= {in_data_i, word_q[23:8]};
                  idx_q  <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     mem_we_q       <= 1'b1;
                     mem_wdata_q    <= {in_data_i, word_q};
                     mem_addr_q     <= words_loaded_q[ADDR_WIDTH-1:0];
                     words_loaded_q <= words_loaded_d;
                     if (last_word) begin
                        state_q <= StCheck;
                     end
                  end
               end
               StCheck: begin
                  if (in_data_i == acc_q) begin
                     state_q      <= StDone;
                     done_q       <= 1'b1;
                     cpu_resetn_q <= 1'b1;
                  end else begin
                     state_q <= StError;
                     error_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_we_o       = mem_we_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign cpu_resetn_o   = cpu_resetn_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign words_loaded_o = words_loaded_q;

endmodule
